rgb_ctrl_sequencer: RTL and testbench

RGB_CTRL_SEQUENCER -- requirements
Module: rgb_ctrl_sequencer

---
 rtl/rgb_ctrl_sequencer.sv | 166 ++++++++++++++++
 tb/tb_rgb_ctrl_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb_ctrl_sequencer.sv
// ----------------------------------------------------------------------------
// rgb_ctrl_sequencer: key/demo driven RGB control settings, applied on frames
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rgb_ctrl_sequencer #(
  parameter int DEMO_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_sel,
  input  logic       key_en,
  input  logic       key_lvl,
  input  logic       demo_en,
  input  logic       vsync,
  output logic       Icontrol1,
  output logic       Icontrol2,
  output logic       rIenable,
  output logic       gIenable,
  output logic       bIenable,
  output logic       brightLevel,
  output logic [1:0] sel_idx,
  output logic       dirty
);

  localparam logic [1:0] SEL_R      = 2'd0;
  localparam logic [1:0] SEL_G      = 2'd1;
  localparam logic [1:0] SEL_B      = 2'd2;
  localparam logic [1:0] SEL_BRIGHT = 2'd3;

  localparam logic [7:0] DEMO_LAST = 8'(DEMO_FRAMES - 1);

  logic       key_sel_q, key_en_q, key_lvl_q, vsync_q, armed_q;
  logic [1:0] sel_q, sel_d;
  logic [1:0] pend_lvl_q, pend_lvl_d;
  logic [3:0] pend_en_q, pend_en_d;
  logic [1:0] act_sel_q, act_sel_d;
  logic [1:0] act_lvl_q, act_lvl_d;
  logic [3:0] act_en_q, act_en_d;
  logic [7:0] cnt_q, cnt_d;
  logic       dirty_q, dirty_d;

  logic       frame_start;
  logic       press_sel, press_en, press_lvl;
  logic       demo_step, demo_wrap;
  logic [3:0] sel_onehot;

  // armed_q masks the first free cycle so a key held through reset is not a press
  assign press_sel   = key_sel & ~key_sel_q & armed_q & ~demo_en;
  assign press_en    = key_en  & ~key_en_q  & armed_q & ~demo_en;
  assign press_lvl   = key_lvl & ~key_lvl_q & armed_q & ~demo_en;
  assign frame_start = vsync & ~vsync_q;

  // Selection FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= SEL_R;
    end else begin
      sel_q <= sel_d;
    end
  end

  // Selection FSM: next state
  always_comb begin
    sel_d = sel_q;
    if (demo_wrap || press_sel) begin
      case (sel_q)
        SEL_R:      sel_d = SEL_G;
        SEL_G:      sel_d = SEL_B;
        SEL_B:      sel_d = SEL_BRIGHT;
        SEL_BRIGHT: sel_d = SEL_R;
        default:    sel_d = SEL_R;
      endcase
    end
  end

  // Selection FSM: outputs
  always_comb begin
    sel_idx    = sel_q;
    sel_onehot = 4'b0001 << sel_q;
  end

  // Demo frame counter and level step
  always_comb begin
    cnt_d     = cnt_q;
    demo_step = 1'b0;
    if (!demo_en) begin
      cnt_d = 8'd0;
    end else if (frame_start) begin
      if (cnt_q == DEMO_LAST) begin
        cnt_d     = 8'd0;
        demo_step = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    demo_wrap = demo_step && (pend_lvl_q == 2'd3);
  end

  always_comb begin
    pend_lvl_d = pend_lvl_q;
    pend_en_d  = pend_en_q;
    if (demo_step || press_lvl) begin
      pend_lvl_d = pend_lvl_q + 2'd1;
    end
    if (demo_wrap) begin
      pend_en_d = 4'b0001 << sel_d;
    end else if (press_en) begin
      pend_en_d = pend_en_q ^ sel_onehot;
    end
  end

  // The active set samples pending before this cycle's updates land
  always_comb begin
    act_sel_d = act_sel_q;
    act_lvl_d = act_lvl_q;
    act_en_d  = act_en_q;
    if (frame_start) begin
      act_sel_d = sel_q;
      act_lvl_d = pend_lvl_q;
      act_en_d  = pend_en_q;
    end
    dirty_d = {sel_d, pend_lvl_d, pend_en_d} != {act_sel_d, act_lvl_d, act_en_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_sel_q  <= 1'b0;
      key_en_q   <= 1'b0;
      key_lvl_q  <= 1'b0;
      vsync_q    <= 1'b0;
      armed_q    <= 1'b0;
      pend_lvl_q <= 2'd3;
      pend_en_q  <= 4'b0000;
      act_sel_q  <= SEL_R;
      act_lvl_q  <= 2'd3;
      act_en_q   <= 4'b0000;
      cnt_q      <= 8'd0;
      dirty_q    <= 1'b0;
    end else begin
      key_sel_q  <= key_sel;
      key_en_q   <= key_en;
      key_lvl_q  <= key_lvl;
      vsync_q    <= vsync;
      armed_q    <= 1'b1;
      pend_lvl_q <= pend_lvl_d;
      pend_en_q  <= pend_en_d;
      act_sel_q  <= act_sel_d;
      act_lvl_q  <= act_lvl_d;
      act_en_q   <= act_en_d;
      cnt_q      <= cnt_d;
      dirty_q    <= dirty_d;
    end
  end

  assign {Icontrol2, Icontrol1} = act_lvl_q;
  assign rIenable    = act_en_q[0];
  assign gIenable    = act_en_q[1];
  assign bIenable    = act_en_q[2];
  assign brightLevel = act_en_q[3];
  assign dirty       = dirty_q;

endmodule

`default_nettype wire

// File: tb/tb_rgb_ctrl_sequencer.sv
// ----------------------------------------------------------------------------
// tb_rgb_ctrl_sequencer: directed self-checking bench for rgb_ctrl_sequencer
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rgb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       reset, key_sel, key_en, key_lvl, demo_en, vsync;
  logic       Icontrol1, Icontrol2, rIenable, gIenable, bIenable, brightLevel;
  logic [1:0] sel_idx;
  logic       dirty;

  int passed = 0;
  int total  = 0;

  rgb_ctrl_sequencer #(.DEMO_FRAMES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_sel    (key_sel),
    .key_en     (key_en),
    .key_lvl    (key_lvl),
    .demo_en    (demo_en),
    .vsync      (vsync),
    .Icontrol1  (Icontrol1),
    .Icontrol2  (Icontrol2),
    .rIenable   (rIenable),
    .gIenable   (gIenable),
    .bIenable   (bIenable),
    .brightLevel(brightLevel),
    .sel_idx    (sel_idx),
    .dirty      (dirty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic frame();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  logic [1:0] exp_lvl [1:10];
  logic [5:0] snap;
  logic       stable;

  initial begin
    exp_lvl = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    reset = 1'b1; key_sel = 1'b0; key_en = 1'b0; key_lvl = 1'b0;
    demo_en = 1'b0; vsync = 1'b0;
    tick();
    tick();
    check("rst_lvl",   {6'd0, Icontrol2, Icontrol1}, 8'd3);
    check("rst_en",    {4'd0, brightLevel, bIenable, gIenable, rIenable}, 8'd0);
    check("rst_sel",   {6'd0, sel_idx}, 8'd0);
    check("rst_dirty", {7'd0, dirty}, 8'd0);
    reset = 1'b0;
    tick();

    // key_en press on R, then transfer
    key_en = 1'b1;
    tick();
    check("en_dirty", {7'd0, dirty}, 8'd1);
    check("en_r_pre", {7'd0, rIenable}, 8'd0);
    key_en = 1'b0;
    tick();
    check("en_r_hold", {7'd0, rIenable}, 8'd0);
    vsync = 1'b1;
    tick();
    check("en_r_post", {7'd0, rIenable}, 8'd1);
    check("en_dirty_clr", {7'd0, dirty}, 8'd0);
    vsync = 1'b0;
    tick();

    // selection wrap and level wrap
    for (int i = 0; i < 4; i++) begin
      key_sel = 1'b1;
      tick();
      check("sel_step", {6'd0, sel_idx}, 8'((i + 1) % 4));
      key_sel = 1'b0;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      key_lvl = 1'b1;
      tick();
      key_lvl = 1'b0;
      tick();
    end
    check("lvl_pre", {6'd0, Icontrol2, Icontrol1}, 8'd3);
    check("lvl_dirty", {7'd0, dirty}, 8'd1);
    vsync = 1'b1;
    tick();
    check("lvl_post", {6'd0, Icontrol2, Icontrol1}, 8'd1);
    vsync = 1'b0;
    tick();

    // press coincident with frame_start
    key_lvl = 1'b1; vsync = 1'b1;
    tick();
    check("coin_lvl", {6'd0, Icontrol2, Icontrol1}, 8'd1);
    check("coin_dirty", {7'd0, dirty}, 8'd1);
    key_lvl = 1'b0; vsync = 1'b0;
    tick();
    check("coin_hold", {6'd0, Icontrol2, Icontrol1}, 8'd1);
    vsync = 1'b1;
    tick();
    check("coin_next", {6'd0, Icontrol2, Icontrol1}, 8'd2);
    check("coin_dirty_clr", {7'd0, dirty}, 8'd0);
    vsync = 1'b0;
    tick();

    // held key gives one press; stuck vsync freezes outputs
    key_sel = 1'b1;
    repeat (100) tick();
    check("held_sel", {6'd0, sel_idx}, 8'd1);
    key_sel = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    snap = {Icontrol2, Icontrol1, brightLevel, bIenable, gIenable, rIenable};
    check("stuck_snap", {2'd0, snap}, 8'b0010_0001);
    key_lvl = 1'b1;
    tick();
    key_lvl = 1'b0;
    stable = 1'b1;
    repeat (1000) begin
      tick();
      if ({Icontrol2, Icontrol1, brightLevel, bIenable, gIenable, rIenable} !== 6'b10_0001)
        stable = 1'b0;
    end
    check("stuck_stable", {7'd0, stable}, 8'd1);
    check("stuck_dirty", {7'd0, dirty}, 8'd1);
    vsync = 1'b0;
    tick();

    // simultaneous key_sel + key_en: enable acts on G, then sel moves to B
    key_sel = 1'b1; key_en = 1'b1;
    tick();
    check("simul_sel", {6'd0, sel_idx}, 8'd2);
    key_sel = 1'b0; key_en = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    check("simul_en", {4'd0, brightLevel, bIenable, gIenable, rIenable}, 8'b0011);
    check("simul_lvl", {6'd0, Icontrol2, Icontrol1}, 8'd3);
    vsync = 1'b0;
    tick();

    // key held through reset deassertion
    key_sel = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("held_rst_sel", {6'd0, sel_idx}, 8'd0);
    key_sel = 1'b0;
    tick();

    // demo sequencing with DEMO_FRAMES=2
    demo_en = 1'b1;
    tick();
    for (int f = 1; f <= 10; f++) begin
      vsync = 1'b1;
      tick();
      check("demo_lvl", {6'd0, Icontrol2, Icontrol1}, {6'd0, exp_lvl[f]});
      if (f == 2) check("demo_sel_wrap", {6'd0, sel_idx}, 8'd1);
      if (f == 3) check("demo_g_only", {4'd0, brightLevel, bIenable, gIenable, rIenable}, 8'b0010);
      vsync = 1'b0;
      tick();
      if (f == 4) begin
        key_sel = 1'b1; key_lvl = 1'b1; key_en = 1'b1;
        tick();
        key_sel = 1'b0; key_lvl = 1'b0; key_en = 1'b0;
        tick();
        check("demo_keys_ignored", {6'd0, sel_idx}, 8'd1);
      end
    end
    check("demo_sel2", {6'd0, sel_idx}, 8'd2);
    check("demo_dirty", {7'd0, dirty}, 8'd1);

    // reset coincident with frame_start while dirty in demo
    reset = 1'b1; vsync = 1'b1;
    tick();
    check("mid_rst_lvl", {6'd0, Icontrol2, Icontrol1}, 8'd3);
    check("mid_rst_en", {4'd0, brightLevel, bIenable, gIenable, rIenable}, 8'd0);
    check("mid_rst_sel", {6'd0, sel_idx}, 8'd0);
    check("mid_rst_dirty", {7'd0, dirty}, 8'd0);
    reset = 1'b0; vsync = 1'b0;
    tick();
    frame();
    check("post_rst_a", {6'd0, Icontrol2, Icontrol1}, 8'd3);
    frame();
    check("post_rst_b", {6'd0, Icontrol2, Icontrol1}, 8'd3);
    frame();
    check("post_rst_c", {6'd0, Icontrol2, Icontrol1}, 8'd0);
    check("post_rst_g", {4'd0, brightLevel, bIenable, gIenable, rIenable}, 8'b0010);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
